// File: rtl/mmp_iddmm_pkg.sv
// Shared definitions for the IDDMM divider: state encoding, default widths, radix step.
// MMP_DIV_RADIX4_EN selects two quotient bits per clock instead of one.
package mmp_iddmm_pkg;

  localparam int unsigned MMP_A_W = 256;
  localparam int unsigned MMP_B_W = 128;

`ifdef MMP_DIV_RADIX4_EN
  localparam int unsigned MMP_DIV_STEP = 2;
`else
  localparam int unsigned MMP_DIV_STEP = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mmp_iddmm_div_step.sv
// One combinational restoring step: shift in a dividend bit, subtract the divisor if it fits.
module mmp_iddmm_div_step
  import mmp_iddmm_pkg::*;
#(
  parameter int unsigned B_W = MMP_B_W
) (
  input  logic [B_W:0]   rem_in,
  input  logic           bit_in,
  input  logic [B_W-1:0] div,
  output logic [B_W:0]   rem_out,
  output logic           q_bit
);

  localparam int unsigned SH_W = B_W + 2;

  logic [SH_W-1:0] shifted;
  logic [SH_W-1:0] diff;

  // rem_in < div on entry, so the kept result always fits B_W+1 bits
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - SH_W'(div);
    q_bit   = (shifted >= SH_W'(div));
    rem_out = (B_W + 1)'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/mmp_iddmm_div256.sv
// Sequential restoring divider, A_W-bit dividend / B_W-bit divisor, valid/ready on both sides.
// MMP_DIV_RADIX4_EN (via mmp_iddmm_pkg) chains two steps per clock.
module mmp_iddmm_div256
  import mmp_iddmm_pkg::*;
#(
  parameter int unsigned A_W = MMP_A_W,
  parameter int unsigned B_W = MMP_B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] a_in,
  input  logic [B_W-1:0] b_in,
  input  logic           valid_in,
  output logic           ready_out,
  output logic [A_W-1:0] q_out,
  output logic [B_W-1:0] r_out,
  output logic           dz_out,
  output logic           valid_out,
  input  logic           ready_in
);

  localparam int unsigned N     = A_W / MMP_DIV_STEP;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  div_state_e       state_q, state_d;
  logic [A_W-1:0]   q_q, q_d;
  logic [B_W:0]     rem_q, rem_d;
  logic [B_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             ready_q, valid_q;

  logic [B_W:0]              rem_chain [MMP_DIV_STEP+1];
  logic [MMP_DIV_STEP-1:0]   qbits;
  logic [A_W-1:0]            q_next;

  // Cascade of restoring steps; the first step produces the more significant quotient bit
  assign rem_chain[0] = rem_q;
  for (genvar g = 0; g < MMP_DIV_STEP; g++) begin : g_step
    mmp_iddmm_div_step #(.B_W(B_W)) u_step (
      .rem_in  (rem_chain[g]),
      .bit_in  (q_q[A_W-1-g]),
      .div     (div_q),
      .rem_out (rem_chain[g+1]),
      .q_bit   (qbits[MMP_DIV_STEP-1-g])
    );
  end
  assign q_next = {q_q[A_W-1-MMP_DIV_STEP:0], qbits};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          div_d = b_in;
          cnt_d = '0;
          if (b_in == '0) begin
            q_d     = '1;
            rem_d   = {1'b0, a_in[B_W-1:0]};
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            q_d     = a_in;
            rem_d   = '0;
            dz_d    = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        q_d   = q_next;
        rem_d = rem_chain[MMP_DIV_STEP];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      ready_q <= (state_d == ST_IDLE);
      valid_q <= (state_d == ST_DONE);
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign q_out     = q_q;
  assign r_out     = rem_q[B_W-1:0];
  assign dz_out    = dz_q;

endmodule

// File: tb/tb_mmp_iddmm_div256.sv
// Directed-vector and random-product bench for mmp_iddmm_div256 (either radix build).
module tb_mmp_iddmm_div256;

  localparam int unsigned A_W = 256;
  localparam int unsigned B_W = 128;
`ifdef MMP_DIV_RADIX4_EN
  localparam int LAT = 129;
`else
  localparam int LAT = 257;
`endif
  localparam int MAX_WAIT = 600;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [A_W-1:0] a_in;
  logic [B_W-1:0] b_in;
  logic           valid_in;
  logic           ready_out;
  logic [A_W-1:0] q_out;
  logic [B_W-1:0] r_out;
  logic           dz_out;
  logic           valid_out;
  logic           ready_in;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmp_iddmm_div256 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .q_out     (q_out),
    .r_out     (r_out),
    .dz_out    (dz_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [A_W-1:0] q;
    logic [B_W-1:0] r;
    logic           dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [A_W-1:0] got, input logic [A_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Accept a request; lat counts edges with the accept edge as edge 1
  task automatic start_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b, output int lat);
    int w = 0;
    while (!ready_out && w < MAX_WAIT) begin @(posedge clk); #1; w++; end
    a_in = a; b_in = b; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    a_in = '0; b_in = '0;
    lat = 1;
    while (!valid_out && lat < MAX_WAIT) begin @(posedge clk); #1; lat++; end
    tests++;
    if (!valid_out) begin
      fails++;
      $display("FAIL timeout got=valid_out 0 exp=valid_out 1 within %0d edges", MAX_WAIT);
    end
  endtask

  task automatic finish_op();
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
  endtask

  initial begin
    int lat;
    logic [A_W-1:0] q_hold;
    logic [B_W-1:0] r_hold;
    logic [B_W-1:0] x, y, rr;
    logic [A_W-1:0] prod;
    bit seen;

    vecs[0] = '{256'd1000, 128'd7, 256'd142, 128'd6, 1'b0};
    vecs[1] = '{{256{1'b1}}, 128'd1, {256{1'b1}}, 128'd0, 1'b0};
    vecs[2] = '{{256{1'b1}}, {128{1'b1}}, {128'd1, 128'd1}, 128'd0, 1'b0};
    vecs[3] = '{256'h1234, 128'd0, {256{1'b1}}, 128'h1234, 1'b1};
    vecs[4] = '{256'd5, 128'd9, 256'd0, 128'd5, 1'b0};
    vecs[5] = '{256'd9, 128'd9, 256'd1, 128'd0, 1'b0};
    vecs[6] = '{{128'd1, 128'd0}, {1'b1, 127'd0}, 256'd2, 128'd0, 1'b0};
    vecs[7] = '{{1'b1, 255'd0}, 128'd2, {2'b01, 254'd0}, 128'd0, 1'b0};
    vecs[8] = '{256'd0, 128'd3, 256'd0, 128'd0, 1'b0};
    vecs[9] = '{256'd17, 128'd5, 256'd3, 128'd2, 1'b0};

    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset_ready", A_W'(ready_out), 256'd1);
    check("reset_valid", A_W'(valid_out), 256'd0);
    check("reset_q", q_out, 256'd0);
    check("reset_r", A_W'(r_out), 256'd0);
    check("reset_dz", A_W'(dz_out), 256'd0);

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_q", i), q_out, vecs[i].q);
      check($sformatf("vec%0d_r", i), A_W'(r_out), A_W'(vecs[i].r));
      check($sformatf("vec%0d_dz", i), A_W'(dz_out), A_W'(vecs[i].dz));
      check($sformatf("vec%0d_lat", i), A_W'(lat), A_W'(vecs[i].dz ? 1 : LAT));
      finish_op();
      check($sformatf("vec%0d_ready_after", i), A_W'(ready_out), 256'd1);
    end

    // Backpressure in DONE with a competing request pulsed
    start_op(256'd1000, 128'd7, lat);
    q_hold = q_out; r_hold = r_out;
    for (int c = 0; c < 10; c++) begin
      a_in = 256'd77; b_in = 128'd3; valid_in = (c % 2) == 0;
      @(posedge clk); #1;
      check("bp_q", q_out, 256'd142);
      check("bp_r", A_W'(r_out), 256'd6);
      check("bp_valid", A_W'(valid_out), 256'd1);
      check("bp_ready", A_W'(ready_out), 256'd0);
    end
    valid_in = 1'b0;
    finish_op();
    check("bp_release_ready", A_W'(ready_out), 256'd1);
    check("bp_release_valid", A_W'(valid_out), 256'd0);
    check("bp_keep_q", q_out, q_hold);
    check("bp_keep_r", A_W'(r_out), A_W'(r_hold));
    repeat (3) @(posedge clk);
    #1 check("bp_nothing_queued", A_W'(valid_out), 256'd0);

    // Reset during RUN at step 100
    a_in = 256'd123456789; b_in = 128'd11; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_ready", A_W'(ready_out), 256'd1);
    check("rst_mid_valid", A_W'(valid_out), 256'd0);
    check("rst_mid_q", q_out, 256'd0);
    seen = 1'b0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(posedge clk); #1;
      if (valid_out) seen = 1'b1;
    end
    check("rst_mid_no_valid", A_W'(seen), 256'd0);

    // Random products x*y+r with r<y
    for (int k = 0; k < 100; k++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom, $urandom};
      y = y >> $urandom_range(0, 120);
      if (y == '0) y = 128'd1;
      rr = {$urandom, $urandom, $urandom, $urandom};
      rr = rr % y;
      prod = A_W'(x) * A_W'(y) + A_W'(rr);
      start_op(prod, y, lat);
      check($sformatf("rand%0d_q", k), q_out, A_W'(x));
      check($sformatf("rand%0d_r", k), A_W'(r_out), A_W'(rr));
      finish_op();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
